// File: rtl/counter_wr_arbiter.sv
// counter_wr_arbiter: round-robin sharing of a counter's load port among NREQ requesters.
// Define CNTARB_VERIFY_EN to add the readback VERIFY state and the sticky err flag;
// without it the grant pulses together with the write strobe and err is tied low.
module counter_wr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic               cnt_wr,
  output logic [DW-1:0]      cnt_wdata,
  input  logic [DW-1:0]      cnt_data,
  output logic               busy,
  output logic [2:0]         owner,
  output logic               err
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    VERIFY = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              cnt_wr_q, cnt_wr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic [2:0]        owner_q, owner_d;

  logic              found;
  logic [2:0]        win;
  logic [DW-1:0]     win_data;
  int unsigned       idx;

`ifdef CNTARB_VERIFY_EN
  logic              err_q, err_d;
`else
  logic [DW-1:0]     unused_cnt_data;
  assign unused_cnt_data = cnt_data;
`endif

  // Round-robin search: first set request starting one past the last winner
  always_comb begin
    found = 1'b0;
    win   = owner_q;
    idx   = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = (32'(owner_q) + i) % NREQ;
      if (!found && req[IW'(idx)]) begin
        found = 1'b1;
        win   = 3'(idx);
      end
    end
  end

  // Load value of the selected requester
  always_comb begin
    win_data = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (3'(j) == win) win_data = req_data[j*DW +: DW];
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d  = state_q;
    gnt_d    = '0;
    cnt_wr_d = 1'b0;
    wdata_d  = wdata_q;
    owner_d  = owner_q;
`ifdef CNTARB_VERIFY_EN
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d  = WRITE;
          cnt_wr_d = 1'b1;
          wdata_d  = win_data;
          owner_d  = win;
`ifndef CNTARB_VERIFY_EN
          gnt_d    = NREQ'(1) << win;
`endif
        end
      end
`ifdef CNTARB_VERIFY_EN
      WRITE: begin
        state_d = VERIFY;
        gnt_d   = NREQ'(1) << owner_q;
      end
      VERIFY: begin
        state_d = IDLE;
        if (cnt_data != wdata_q) err_d = 1'b1;
      end
`else
      WRITE: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      cnt_wr_q <= 1'b0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      owner_q  <= 3'(NREQ - 1);
`ifdef CNTARB_VERIFY_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      cnt_wr_q <= cnt_wr_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      owner_q  <= owner_d;
`ifdef CNTARB_VERIFY_EN
      err_q    <= err_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign cnt_wr    = cnt_wr_q;
  assign cnt_wdata = wdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
`ifdef CNTARB_VERIFY_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule
